// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and framebuffer scan-out engine.
//
// It divides CLK down to a pixel enable and runs the horizontal and vertical
// counters from it. It issues framebuffer reads during the visible region and
// lines up sync, blank and pixel data with the read latency of the
// framebuffer.
//
// Ports:
//   CLK, RESET   system clock, asynchronous active-high reset
//   rd_en        framebuffer read strobe (visible region AND pix_ce)
//   rd_x, rd_y   framebuffer column/row (counters >> SCALE_SH)
//   rd_data      framebuffer data, valid RD_LAT pixel enables after rd_en
//   pix_out      pixel to palette, 0 while blanked
//   hs, vs       horizontal/vertical sync, active level SYNC_POL
//   blank        active-low blank (1 = visible pixel)
//   sync         composite sync, tied to 0
//   pixel_clk    pixel clock for the DAC (50% duty for even CLK_DIV)
//   pix_ce       one-CLK pixel enable
//   frame_start  one-CLK pulse when the counters enter vertical blanking
//   line_start   one-CLK pulse when hcnt wraps to 0
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int RD_LAT   = 2,
  parameter int SCALE_SH = 0,
  parameter int SYNC_POL = 0,
  parameter int DW       = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic          rd_en,
  output logic [9:0]    rd_x,
  output logic [9:0]    rd_y,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] pix_out,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic          pixel_clk,
  output logic          pix_ce,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic SYNC_LVL = 1'(SYNC_POL);

  // The counters are 10 bits wide, so any larger timing cannot be built.
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_scanout: H_TOT/V_TOT must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
    $error("vga_scanout: CLK_DIV must be 1..8");
  end
  if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_lat
    $error("vga_scanout: RD_LAT must be 0..4");
  end
  if (SCALE_SH < 0 || SCALE_SH > 2) begin : g_bad_scale
    $error("vga_scanout: SCALE_SH must be 0..2");
  end

  logic [2:0]      div_q, div_d;
  logic            pix_ce_q, pix_ce_d;
  logic            pixel_clk_q, pixel_clk_d;
  logic [9:0]      hcnt_q, hcnt_d;
  logic [9:0]      vcnt_q, vcnt_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic [RD_LAT:0] act_sr_q, act_sr_d;
  logic [RD_LAT:0] hs_sr_q, hs_sr_d;
  logic [RD_LAT:0] vs_sr_q, vs_sr_d;
  logic [DW-1:0]   pix_out_q, pix_out_d;

  logic h_last, v_last;
  logic act_raw, hs_raw, vs_raw;

  // The 11-bit compares keep boundaries that equal 1024 exact.
  always_comb begin
    h_last  = (hcnt_q == 10'(H_TOT - 1));
    v_last  = (vcnt_q == 10'(V_TOT - 1));
    act_raw = ({1'b0, hcnt_q} < 11'(H_ACTIVE)) &&
              ({1'b0, vcnt_q} < 11'(V_ACTIVE));
    hs_raw  = ({1'b0, hcnt_q} >= 11'(H_ACTIVE + H_FP)) &&
              ({1'b0, hcnt_q} <  11'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw  = ({1'b0, vcnt_q} >= 11'(V_ACTIVE + V_FP)) &&
              ({1'b0, vcnt_q} <  11'(V_ACTIVE + V_FP + V_SYNC));
  end

  // pix_ce is registered from the divider. The divider starts at 0, so the
  // first enable appears CLK_DIV cycles after reset is released. pixel_clk
  // is low for the first half of each pixel. Its rising edge then falls
  // mid-pixel, away from the edge where the outputs change.
  always_comb begin
    div_d = div_q;
    if (div_q == 3'(CLK_DIV - 1)) begin
      div_d = 3'd0;
    end else begin
      div_d = div_q + 3'd1;
    end
    pix_ce_d    = (div_q == 3'(CLK_DIV - 1));
    pixel_clk_d = (div_d == 3'd0) || (div_d > 3'(CLK_DIV / 2));
  end

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce_q) begin
      line_start_d  = h_last;
      frame_start_d = h_last && (vcnt_q == 10'(V_ACTIVE - 1));
      if (h_last) begin
        hcnt_d = 10'd0;
        vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // The delay line is RD_LAT+1 stages. The last stage drives the outputs
  // directly. The next-state of that stage is the RD_LAT-delayed flag that
  // is aligned with rd_data, and it gates pix_out.
  always_comb begin
    act_sr_d  = act_sr_q;
    hs_sr_d   = hs_sr_q;
    vs_sr_d   = vs_sr_q;
    pix_out_d = pix_out_q;
    if (pix_ce_q) begin
      act_sr_d[0] = act_raw;
      hs_sr_d[0]  = hs_raw;
      vs_sr_d[0]  = vs_raw;
      for (int i = 1; i <= RD_LAT; i++) begin
        act_sr_d[i] = act_sr_q[i-1];
        hs_sr_d[i]  = hs_sr_q[i-1];
        vs_sr_d[i]  = vs_sr_q[i-1];
      end
      pix_out_d = act_sr_d[RD_LAT] ? rd_data : '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q         <= 3'd0;
      pix_ce_q      <= 1'b0;
      pixel_clk_q   <= 1'b0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      act_sr_q      <= '0;
      hs_sr_q       <= '0;
      vs_sr_q       <= '0;
      pix_out_q     <= '0;
    end else begin
      div_q         <= div_d;
      pix_ce_q      <= pix_ce_d;
      pixel_clk_q   <= pixel_clk_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      act_sr_q      <= act_sr_d;
      hs_sr_q       <= hs_sr_d;
      vs_sr_q       <= vs_sr_d;
      pix_out_q     <= pix_out_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign pixel_clk   = pixel_clk_q;
  assign rd_en       = pix_ce_q && act_raw;
  assign rd_x        = hcnt_q >> SCALE_SH;
  assign rd_y        = vcnt_q >> SCALE_SH;
  assign pix_out     = pix_out_q;
  assign blank       = act_sr_q[RD_LAT];
  assign hs          = hs_sr_q[RD_LAT] ? SYNC_LVL : ~SYNC_LVL;
  assign vs          = vs_sr_q[RD_LAT] ? SYNC_LVL : ~SYNC_LVL;
  assign sync        = 1'b0;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

  // Small timing: H 8/2/2/2 (H_TOT 14), V 4/1/1/1 (V_TOT 7)
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  // dut_a: CLK_DIV=2, RD_LAT=2, SCALE_SH=0, SYNC_POL=0
  logic       rd_en_a, hs_a, vs_a, blank_a, sync_a, pixel_clk_a, pix_ce_a, frame_start_a, line_start_a;
  logic [9:0] rd_x_a, rd_y_a;
  logic [7:0] rd_data_a, pix_out_a;
  // dut_b: CLK_DIV=1, RD_LAT=0, SCALE_SH=1, SYNC_POL=1
  logic       rd_en_b, hs_b, vs_b, blank_b, sync_b, pixel_clk_b, pix_ce_b, frame_start_b, line_start_b;
  logic [9:0] rd_x_b, rd_y_b;
  logic [7:0] rd_data_b, pix_out_b;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .RD_LAT(2), .SCALE_SH(0), .SYNC_POL(0), .DW(8)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .rd_en(rd_en_a), .rd_x(rd_x_a), .rd_y(rd_y_a),
    .rd_data(rd_data_a), .pix_out(pix_out_a), .hs(hs_a), .vs(vs_a), .blank(blank_a),
    .sync(sync_a), .pixel_clk(pixel_clk_a), .pix_ce(pix_ce_a),
    .frame_start(frame_start_a), .line_start(line_start_a)
  );

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .RD_LAT(0), .SCALE_SH(1), .SYNC_POL(1), .DW(8)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .rd_en(rd_en_b), .rd_x(rd_x_b), .rd_y(rd_y_b),
    .rd_data(rd_data_b), .pix_out(pix_out_b), .hs(hs_b), .vs(vs_b), .blank(blank_b),
    .sync(sync_b), .pixel_clk(pixel_clk_b), .pix_ce(pix_ce_b),
    .frame_start(frame_start_b), .line_start(line_start_b)
  );

  // Framebuffer models: pixel value = {row[3:0], col[3:0]}
  logic [7:0] fb1, fb2;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fb1 <= 8'h00;
      fb2 <= 8'h00;
    end else if (pix_ce_a) begin
      if (rd_en_a) fb1 <= {rd_y_a[3:0], rd_x_a[3:0]};
      fb2 <= fb1;
    end
  end
  assign rd_data_a = fb2;
  assign rd_data_b = {rd_y_b[3:0], rd_x_b[3:0]};

  // CLK edges since reset release
  int cyc;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    if (cyc < c) check("wait_timeout", c, cyc, c);
  endtask

  typedef struct {
    int         n;
    logic       rd_en;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic [7:0] pix;
  } vec_t;

  vec_t va[15];
  vec_t vb[14];

  int ls_a1, fs_a1, fs_a2, ls_b1, fs_b1, fs_b2, ls_a_hi, ls_b_hi, ls_b99, fs_b99;

  task automatic watch(input int max_c);
    ls_a1 = -1; fs_a1 = -1; fs_a2 = -1; ls_b1 = -1; fs_b1 = -1; fs_b2 = -1;
    ls_a_hi = 0; ls_b_hi = 0; ls_b99 = -1; fs_b99 = -1;
    for (int c = 1; c <= max_c; c++) begin
      wait_cyc(c);
      if (line_start_a) begin
        ls_a_hi++;
        if (ls_a1 < 0) ls_a1 = c;
      end
      if (frame_start_a) begin
        if (fs_a1 < 0) fs_a1 = c;
        else if (fs_a2 < 0) fs_a2 = c;
      end
      if (line_start_b) begin
        ls_b_hi++;
        if (ls_b1 < 0) ls_b1 = c;
      end
      if (frame_start_b) begin
        if (fs_b1 < 0) fs_b1 = c;
        else if (fs_b2 < 0) fs_b2 = c;
      end
      if (c == 99) begin
        ls_b99 = int'(line_start_b);
        fs_b99 = int'(frame_start_b);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // n = pixel index; outputs show pixel n-3 (dut_a) / n-1 (dut_b)
    //         n   rd_en  rd_x    rd_y   blank hs    vs    pix
    va[0]  = '{0,   1'b1, 10'd0,  10'd0, 1'b0, 1'b1, 1'b1, 8'h00};
    va[1]  = '{3,   1'b1, 10'd3,  10'd0, 1'b1, 1'b1, 1'b1, 8'h00};
    va[2]  = '{10,  1'b0, 10'd10, 10'd0, 1'b1, 1'b1, 1'b1, 8'h07};
    va[3]  = '{11,  1'b0, 10'd11, 10'd0, 1'b0, 1'b1, 1'b1, 8'h00};
    va[4]  = '{13,  1'b0, 10'd13, 10'd0, 1'b0, 1'b0, 1'b1, 8'h00};
    va[5]  = '{14,  1'b1, 10'd0,  10'd1, 1'b0, 1'b0, 1'b1, 8'h00};
    va[6]  = '{15,  1'b1, 10'd1,  10'd1, 1'b0, 1'b1, 1'b1, 8'h00};
    va[7]  = '{20,  1'b1, 10'd6,  10'd1, 1'b1, 1'b1, 1'b1, 8'h13};
    va[8]  = '{45,  1'b1, 10'd3,  10'd3, 1'b1, 1'b1, 1'b1, 8'h30};
    va[9]  = '{52,  1'b0, 10'd10, 10'd3, 1'b1, 1'b1, 1'b1, 8'h37};
    va[10] = '{59,  1'b0, 10'd3,  10'd4, 1'b0, 1'b1, 1'b1, 8'h00};
    va[11] = '{73,  1'b0, 10'd3,  10'd5, 1'b0, 1'b1, 1'b0, 8'h00};
    va[12] = '{87,  1'b0, 10'd3,  10'd6, 1'b0, 1'b1, 1'b1, 8'h00};
    va[13] = '{98,  1'b1, 10'd0,  10'd0, 1'b0, 1'b0, 1'b1, 8'h00};
    va[14] = '{101, 1'b1, 10'd3,  10'd0, 1'b1, 1'b1, 1'b1, 8'h00};

    vb[0]  = '{0,   1'b1, 10'd0,  10'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    vb[1]  = '{1,   1'b1, 10'd0,  10'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vb[2]  = '{4,   1'b1, 10'd2,  10'd0, 1'b1, 1'b0, 1'b0, 8'h01};
    vb[3]  = '{8,   1'b0, 10'd4,  10'd0, 1'b1, 1'b0, 1'b0, 8'h03};
    vb[4]  = '{9,   1'b0, 10'd4,  10'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    vb[5]  = '{11,  1'b0, 10'd5,  10'd0, 1'b0, 1'b1, 1'b0, 8'h00};
    vb[6]  = '{13,  1'b0, 10'd6,  10'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    vb[7]  = '{14,  1'b1, 10'd0,  10'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    vb[8]  = '{20,  1'b1, 10'd3,  10'd0, 1'b1, 1'b0, 1'b0, 8'h02};
    vb[9]  = '{32,  1'b1, 10'd2,  10'd1, 1'b1, 1'b0, 1'b0, 8'h11};
    vb[10] = '{50,  1'b0, 10'd4,  10'd1, 1'b1, 1'b0, 1'b0, 8'h13};
    vb[11] = '{71,  1'b0, 10'd0,  10'd2, 1'b0, 1'b0, 1'b1, 8'h00};
    vb[12] = '{85,  1'b0, 10'd0,  10'd3, 1'b0, 1'b0, 1'b0, 8'h00};
    vb[13] = '{99,  1'b1, 10'd0,  10'd0, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_pix_ce_a", 0, pix_ce_a, 1'b0);
    check("rst_pix_ce_b", 0, pix_ce_b, 1'b0);
    check("rst_pixel_clk_b", 0, pixel_clk_b, 1'b0);
    check("rst_rd_en_a", 0, rd_en_a, 1'b0);
    check("rst_hs_a", 0, hs_a, 1'b1);
    check("rst_vs_a", 0, vs_a, 1'b1);
    check("rst_hs_b", 0, hs_b, 1'b0);
    check("rst_vs_b", 0, vs_b, 1'b0);
    check("rst_blank_a", 0, blank_a, 1'b0);
    check("rst_pix_out_a", 0, pix_out_a, 8'h00);
    check("rst_line_start_a", 0, line_start_a, 1'b0);
    check("rst_frame_start_b", 0, frame_start_b, 1'b0);
    check("rst_sync_a", 0, sync_a, 1'b0);

    RESET = 1'b0;
    fork
      begin : table_a
        for (int i = 0; i < 15; i++) begin
          wait_cyc(2 * va[i].n + 2);
          check("a_pix_ce", va[i].n, pix_ce_a, 1'b1);
          check("a_rd_en", va[i].n, rd_en_a, va[i].rd_en);
          check("a_rd_x", va[i].n, rd_x_a, va[i].rd_x);
          check("a_rd_y", va[i].n, rd_y_a, va[i].rd_y);
          check("a_blank", va[i].n, blank_a, va[i].blank);
          check("a_hs", va[i].n, hs_a, va[i].hs);
          check("a_vs", va[i].n, vs_a, va[i].vs);
          check("a_pix_out", va[i].n, pix_out_a, va[i].pix);
        end
      end
      begin : table_b
        for (int i = 0; i < 14; i++) begin
          wait_cyc(vb[i].n + 1);
          check("b_pix_ce", vb[i].n, pix_ce_b, 1'b1);
          check("b_rd_en", vb[i].n, rd_en_b, vb[i].rd_en);
          check("b_rd_x", vb[i].n, rd_x_b, vb[i].rd_x);
          check("b_rd_y", vb[i].n, rd_y_b, vb[i].rd_y);
          check("b_blank", vb[i].n, blank_b, vb[i].blank);
          check("b_hs", vb[i].n, hs_b, vb[i].hs);
          check("b_vs", vb[i].n, vs_b, vb[i].vs);
          check("b_pix_out", vb[i].n, pix_out_b, vb[i].pix);
        end
      end
      begin : enables
        wait_cyc(1);
        check("pix_ce_a_c1", 1, pix_ce_a, 1'b0);
        check("pixel_clk_a_c1", 1, pixel_clk_a, 1'b0);
        check("pix_ce_b_c1", 1, pix_ce_b, 1'b1);
        check("pixel_clk_b_c1", 1, pixel_clk_b, 1'b1);
        wait_cyc(2);
        check("pix_ce_a_c2", 2, pix_ce_a, 1'b1);
        check("pixel_clk_a_c2", 2, pixel_clk_a, 1'b1);
        wait_cyc(3);
        check("pix_ce_a_c3", 3, pix_ce_a, 1'b0);
        check("pixel_clk_a_c3", 3, pixel_clk_a, 1'b0);
        check("pix_ce_b_c3", 3, pix_ce_b, 1'b1);
      end
      watch(320);
    join

    check("ls_a_first", 0, ls_a1, 29);
    check("fs_a_first", 0, fs_a1, 113);
    check("fs_a_second", 0, fs_a2, 309);
    check("ls_a_high_cycles", 0, ls_a_hi, 11);
    check("ls_b_first", 0, ls_b1, 15);
    check("fs_b_first", 0, fs_b1, 57);
    check("fs_b_second", 0, fs_b2, 155);
    check("ls_b_high_cycles", 0, ls_b_hi, 22);
    check("ls_b_at_vwrap", 99, ls_b99, 1);
    check("fs_b_at_vwrap", 99, fs_b99, 0);

    // Mid-frame reset while a visible, non-zero pixel is on the output
    begin
      int k;
      k = 0;
      while (!(blank_a === 1'b1 && pix_out_a !== 8'h00) && k < 300) begin
        @(negedge CLK);
        k++;
      end
      check("pre_reset_visible", k, blank_a && (pix_out_a != 8'h00), 1'b1);
    end
    RESET = 1'b1;
    #1;
    check("mid_rst_blank_a", 0, blank_a, 1'b0);
    check("mid_rst_pix_out_a", 0, pix_out_a, 8'h00);
    check("mid_rst_hs_a", 0, hs_a, 1'b1);
    check("mid_rst_rd_en_a", 0, rd_en_a, 1'b0);
    check("mid_rst_rd_x_a", 0, rd_x_a, 10'd0);
    check("mid_rst_rd_y_a", 0, rd_y_a, 10'd0);
    check("mid_rst_pix_ce_a", 0, pix_ce_a, 1'b0);
    check("mid_rst_pixel_clk_a", 0, pixel_clk_a, 1'b0);
    check("mid_rst_hs_b", 0, hs_b, 1'b0);
    check("mid_rst_blank_b", 0, blank_b, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    watch(120);
    check("restart_ls_a", 0, ls_a1, 29);
    check("restart_fs_a", 0, fs_a1, 113);
    check("restart_ls_b", 0, ls_b1, 15);
    check("restart_fs_b", 0, fs_b1, 57);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
